pkt_rx_reader: RTL and testbench
================================

PKT_RX_READER -- requirements
Module: pkt_rx_reader

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, output buffer depth in 64-bit words (power of 2, >=4).
REQ-002 Parameter: MAX_LEN, 16'd9600, byte length above which a packet is flagged oversize.
REQ-003 Port: clk_156m25  in  1  single block clock, all logic rising-edge.
REQ-004 Port: reset_156m25_n  in  1  asynchronous, active-low reset.
REQ-005 Ports (MAC side): pkt_rx_avail in 1; pkt_rx_data in 64; pkt_rx_val/sop/eop/err in 1 each; pkt_rx_mod in 3; pkt_rx_ren out 1 (registered).
REQ-006 Ports (downstream stream): out_data out 64; out_val/out_sop/out_eop/out_err out 1 each; out_mod out 3; out_rdy in 1.
REQ-007 Ports (status): pkt_done out 1, pulse per completed packet; pkt_len out 16, byte length of last completed packet; stat_pkt_cnt out 32; stat_err_cnt out 16; stat_frm_cnt out 16.

Function
REQ-008 FSM states: IDLE, READ, GAP.
REQ-009 IDLE -> READ when pkt_rx_avail=1 and FIFO occupancy <= FIFO_DEPTH-3; pkt_rx_ren goes high the following cycle.
REQ-010 READ: pkt_rx_ren=1 while occupancy <= FIFO_DEPTH-3, else 0 (throttle); READ -> GAP on accepted word with pkt_rx_val=1 and pkt_rx_eop=1.
REQ-011 GAP: pkt_rx_ren=0 for exactly one cycle; GAP -> IDLE unconditionally.
REQ-012 Read latency: MAC data valid (pkt_rx_val=1) one cycle after pkt_rx_ren=1; every pkt_rx_val=1 word is accepted regardless of FSM state (in-flight words never dropped).
REQ-013 Throttle threshold guarantees no FIFO overflow; an overflow is a design error, not a runtime condition.
REQ-014 Framing tracked by in_pkt flag: set on accepted sop, cleared on accepted eop (sop+eop same word: single-word packet, flag stays 0).
REQ-015 Word with val=1, sop=0 while in_pkt=0: discarded, stat_frm_cnt increments.
REQ-016 Word with val=1, sop=1 while in_pkt=1: stat_frm_cnt increments; a synthetic terminator is not generated; the FIFO entry immediately preceding is not modified; new packet starts, its length counter restarts.
REQ-017 Accepted in-frame words pushed to FIFO with data, sop, eop, mod, err unchanged; out_err additionally forced 1 on eop word if byte length > MAX_LEN.
REQ-018 Byte length: +8 per non-eop word; eop word adds 8 if mod=0 else mod; saturates at 16'hFFFF.
REQ-019 On eop accept: pkt_len updated, pkt_done pulses 1 cycle next edge, stat_pkt_cnt +1 (wraps mod 2^32), stat_err_cnt +1 if err or oversize (saturates at 16'hFFFF).
REQ-020 stat_frm_cnt saturates at 16'hFFFF.
REQ-021 Downstream: entry transferred when out_val=1 and out_rdy=1; out_val=1 whenever FIFO non-empty; out_* stable while out_val=1 and out_rdy=0.
REQ-022 Simultaneous push and pop on same cycle: both take effect, occupancy unchanged; pop-then-push on empty FIFO not bypassed (out_val one cycle after push earliest).
REQ-023 Pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.

Reset
REQ-024 reset_156m25_n=0 asynchronously: FSM=IDLE, FIFO emptied, in_pkt=0, all outputs 0 (pkt_rx_ren, out_*, pkt_done, pkt_len, all stat counters).
REQ-025 Reset mid-packet: partial packet discarded, not counted; after release, first accepted word must carry sop or is counted as framing error.
REQ-026 Outputs remain 0 until first rising clock edge after reset deassertion.

Verification
REQ-027 Single 3-word packet, mod=5, out_rdy=1 -> 3 words out in order, pkt_len=21, stat_pkt_cnt=1, pkt_done one pulse, ren low for 1 GAP cycle after eop.
REQ-028 out_rdy=0 held during 10-word packet, FIFO_DEPTH=4 -> pkt_rx_ren drops with occupancy 2, no word lost; release out_rdy -> all 10 words out, pkt_len=80.
REQ-029 Word val=1 sop=0 with no packet open -> discarded, stat_frm_cnt=1, no out_val.
REQ-030 Packet with pkt_rx_err=1 on eop, then 1201-word packet mod=0 (9608 bytes) -> both eop words out_err=1, stat_err_cnt=2.
REQ-031 Assert reset after 2nd word of 5-word packet -> all outputs 0 immediately; next clean 1-word packet (sop+eop, mod=4) -> pkt_len=4, stat_pkt_cnt=1.
REQ-032 Back-to-back packets with pkt_rx_avail held high -> each packet separated by exactly one GAP cycle, stat_pkt_cnt equals packets sent.

Source files
------------

// File: rtl/pkt_rx_reader.sv
// pkt_rx_reader: drains packets from a 10G MAC receive interface (1-cycle
// read latency) into a small output FIFO, checks framing, measures packet
// length and keeps packet/error/framing statistics.
module pkt_rx_reader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] MAX_LEN    = 16'd9600
) (
   input  logic        clk_156m25,
   input  logic        reset_156m25_n,
   // MAC side
   input  logic        pkt_rx_avail,
   input  logic [63:0] pkt_rx_data,
   input  logic        pkt_rx_val,
   input  logic        pkt_rx_sop,
   input  logic        pkt_rx_eop,
   input  logic        pkt_rx_err,
   input  logic [2:0]  pkt_rx_mod,
   output logic        pkt_rx_ren,
   // downstream stream
   output logic [63:0] out_data,
   output logic        out_val,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_err,
   output logic [2:0]  out_mod,
   input  logic        out_rdy,
   // status
   output logic        pkt_done,
   output logic [15:0] pkt_len,
   output logic [31:0] stat_pkt_cnt,
   output logic [15:0] stat_err_cnt,
   output logic [15:0] stat_frm_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   // Two reads may already be in flight when the throttle kicks in, so
   // reading is only allowed while at least three entries are free.
   localparam logic [CW-1:0] THRESH = CW'(FIFO_DEPTH - 3);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic        err;
      logic [2:0]  mod;
   } fifo_entry_t;

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_ren;
   logic           w_ren_nxt;

   fifo_entry_t    r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           w_room;
   logic           w_push;
   logic           w_pop;
   logic           w_out_val;
   fifo_entry_t    w_head;
   fifo_entry_t    w_entry;

   logic           r_in_pkt;
   logic [15:0]    r_len_acc;
   logic           w_in_frame;
   logic           w_frm_err;
   logic           w_pkt_end;
   logic [15:0]    w_len_add;
   logic [15:0]    w_len_base;
   logic [16:0]    w_len_sum;
   logic [15:0]    w_len_new;
   logic           w_oversize;

   logic           r_pkt_done;
   logic [15:0]    r_pkt_len;
   logic [31:0]    r_pkt_cnt;
   logic [15:0]    r_err_cnt;
   logic [15:0]    r_frm_cnt;

   // ------------------------------------------------------------------
   // Framing and length datapath
   // ------------------------------------------------------------------
   // A word belongs to a frame if it opens one or a frame is already open;
   // anything else is dropped and counted as a framing error.
   assign w_in_frame = pkt_rx_val && (pkt_rx_sop || r_in_pkt);
   assign w_frm_err  = pkt_rx_val && (pkt_rx_sop ? r_in_pkt : !r_in_pkt);
   assign w_pkt_end  = w_in_frame && pkt_rx_eop;

   // mod=0 on the last word means all eight bytes are valid.
   assign w_len_add  = (pkt_rx_eop && (pkt_rx_mod != 3'd0)) ? {13'd0, pkt_rx_mod} : 16'd8;
   // A sop restarts the count, even when it interrupts an open packet.
   assign w_len_base = pkt_rx_sop ? 16'd0 : r_len_acc;
   assign w_len_sum  = {1'b0, w_len_base} + {1'b0, w_len_add};
   assign w_len_new  = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
   assign w_oversize = (w_len_new > MAX_LEN);

   assign w_entry.data = pkt_rx_data;
   assign w_entry.sop  = pkt_rx_sop;
   assign w_entry.eop  = pkt_rx_eop;
   assign w_entry.err  = pkt_rx_err || (pkt_rx_eop && w_oversize);
   assign w_entry.mod  = pkt_rx_mod;

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   assign w_room    = (r_count <= THRESH);
   assign w_out_val = (r_count != '0);
   assign w_push    = w_in_frame;
   assign w_pop     = w_out_val && out_rdy;
   assign w_head    = r_mem[r_rd_ptr];

   // FIFO storage write port
   // NOTE: the storage array carries no reset; validity is tracked by
   // r_count alone, which keeps the RAM free of reset fan-out.
   always_ff @(posedge clk_156m25) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // FIFO pointers and occupancy; push and pop in one cycle cancel out
   // NOTE: sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head entry is presented directly; outputs read zero while empty.
   assign out_val  = w_out_val;
   assign out_data = w_out_val ? w_head.data : 64'd0;
   assign out_sop  = w_out_val && w_head.sop;
   assign out_eop  = w_out_val && w_head.eop;
   assign out_err  = w_out_val && w_head.err;
   assign out_mod  = w_out_val ? w_head.mod : 3'd0;

   // ------------------------------------------------------------------
   // Frame tracking and statistics
   // ------------------------------------------------------------------
   // Open-packet flag and running byte count
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_in_pkt  <= 1'b0;
         r_len_acc <= 16'd0;
      end else if (w_in_frame) begin
         r_in_pkt  <= !pkt_rx_eop;
         r_len_acc <= w_len_new;
      end
   end

   // Per-packet completion report and statistics counters
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_pkt_done <= 1'b0;
         r_pkt_len  <= 16'd0;
         r_pkt_cnt  <= 32'd0;
         r_err_cnt  <= 16'd0;
         r_frm_cnt  <= 16'd0;
      end else begin
         r_pkt_done <= w_pkt_end;
         if (w_pkt_end) begin
            r_pkt_len <= w_len_new;
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if ((pkt_rx_err || w_oversize) && (r_err_cnt != 16'hFFFF)) begin
               r_err_cnt <= r_err_cnt + 16'd1;
            end
         end
         if (w_frm_err && (r_frm_cnt != 16'hFFFF)) begin
            r_frm_cnt <= r_frm_cnt + 16'd1;
         end
      end
   end

   assign pkt_done     = r_pkt_done;
   assign pkt_len      = r_pkt_len;
   assign stat_pkt_cnt = r_pkt_cnt;
   assign stat_err_cnt = r_err_cnt;
   assign stat_frm_cnt = r_frm_cnt;

   // ------------------------------------------------------------------
   // Read-control FSM
   // ------------------------------------------------------------------
   // State and registered read enable
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_state <= ST_IDLE;
         r_ren   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ren   <= w_ren_nxt;
      end
   end

   // Next state and next read enable
   // NOTE: both outputs get a default before the case so no path through
   // this block can leave them unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_ren_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (pkt_rx_avail && w_room) begin
               w_state_nxt = ST_READ;
               w_ren_nxt   = 1'b1;
            end
         end
         ST_READ: begin
            if (pkt_rx_val && pkt_rx_eop) begin
               w_state_nxt = ST_GAP;
            end else begin
               w_ren_nxt = w_room;
            end
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign pkt_rx_ren = r_ren;

endmodule

// File: tb/tb_pkt_rx_reader.sv
`timescale 1ns/1ps
// Bench for pkt_rx_reader: a MAC model answers pkt_rx_ren with one cycle of
// latency, directed packets load both the MAC queue and a scoreboard of
// expected downstream words, and an independent monitor checks the stream.
module tb_pkt_rx_reader;

   localparam int FIFO_DEPTH = 4;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic        err;
      logic [2:0]  mod;
   } word_t;

   logic        clk_156m25     = 1'b0;
   logic        reset_156m25_n = 1'b0;
   logic        pkt_rx_avail   = 1'b0;
   logic [63:0] pkt_rx_data    = 64'd0;
   logic        pkt_rx_val     = 1'b0;
   logic        pkt_rx_sop     = 1'b0;
   logic        pkt_rx_eop     = 1'b0;
   logic        pkt_rx_err     = 1'b0;
   logic [2:0]  pkt_rx_mod     = 3'd0;
   logic        pkt_rx_ren;
   logic [63:0] out_data;
   logic        out_val;
   logic        out_sop;
   logic        out_eop;
   logic        out_err;
   logic [2:0]  out_mod;
   logic        out_rdy        = 1'b1;
   logic        pkt_done;
   logic [15:0] pkt_len;
   logic [31:0] stat_pkt_cnt;
   logic [15:0] stat_err_cnt;
   logic [15:0] stat_frm_cnt;

   int    total = 0;
   int    bad   = 0;
   word_t mac_q[$];
   word_t sb_q[$];
   int    words_sent    = 0;
   int    done_cnt      = 0;
   int    gap_checks    = 0;
   logic  chk_gap       = 1'b0;
   logic  ren_after_eop = 1'b1;

   pkt_rx_reader #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .MAX_LEN    (16'd9600)
   ) dut (
      .clk_156m25     (clk_156m25),
      .reset_156m25_n (reset_156m25_n),
      .pkt_rx_avail   (pkt_rx_avail),
      .pkt_rx_data    (pkt_rx_data),
      .pkt_rx_val     (pkt_rx_val),
      .pkt_rx_sop     (pkt_rx_sop),
      .pkt_rx_eop     (pkt_rx_eop),
      .pkt_rx_err     (pkt_rx_err),
      .pkt_rx_mod     (pkt_rx_mod),
      .pkt_rx_ren     (pkt_rx_ren),
      .out_data       (out_data),
      .out_val        (out_val),
      .out_sop        (out_sop),
      .out_eop        (out_eop),
      .out_err        (out_err),
      .out_mod        (out_mod),
      .out_rdy        (out_rdy),
      .pkt_done       (pkt_done),
      .pkt_len        (pkt_len),
      .stat_pkt_cnt   (stat_pkt_cnt),
      .stat_err_cnt   (stat_err_cnt),
      .stat_frm_cnt   (stat_frm_cnt)
   );

   always #3 clk_156m25 = ~clk_156m25;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue a packet at the MAC; when expect_out is set the words are also
   // queued as expected output, with exp_err as the required eop error flag.
   task automatic send_pkt(input int id, input int n, input logic [2:0] mod,
                           input logic err, input logic exp_err, input logic expect_out);
      word_t w;
      for (int i = 0; i < n; i++) begin
         w.data = {16'(id), 48'(i)};
         w.sop  = (i == 0);
         w.eop  = (i == n - 1);
         w.mod  = (i == n - 1) ? mod : 3'd0;
         w.err  = (i == n - 1) ? err : 1'b0;
         mac_q.push_back(w);
         if (expect_out) begin
            w.err = (i == n - 1) ? exp_err : 1'b0;
            sb_q.push_back(w);
         end
      end
   endtask

   // Wait until the MAC and the scoreboard are both empty, then settle.
   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((mac_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
         @(posedge clk_156m25);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: mac words left %0d, expected outputs left %0d, required 0",
                  name, mac_q.size(), sb_q.size());
      end
      repeat (6) @(posedge clk_156m25);
      @(negedge clk_156m25);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ren"},      64'(pkt_rx_ren), 64'd0);
      check({tag, "_out_val"},  64'(out_val), 64'd0);
      check({tag, "_out_data"}, out_data, 64'd0);
      check({tag, "_out_flag"}, 64'({out_sop, out_eop, out_err, out_mod}), 64'd0);
      check({tag, "_done"},     64'(pkt_done), 64'd0);
      check({tag, "_len"},      64'(pkt_len), 64'd0);
      check({tag, "_pkt_cnt"},  64'(stat_pkt_cnt), 64'd0);
      check({tag, "_err_cnt"},  64'(stat_err_cnt), 64'd0);
      check({tag, "_frm_cnt"},  64'(stat_frm_cnt), 64'd0);
   endtask

   // MAC model: a word appears the cycle after pkt_rx_ren is seen high.
   initial begin : mac_model
      logic  ren_s;
      word_t w;
      forever begin
         @(negedge clk_156m25);
         ren_s = pkt_rx_ren;
         @(posedge clk_156m25);
         #1;
         if (ren_s && mac_q.size() != 0) begin
            w           = mac_q.pop_front();
            pkt_rx_val  = 1'b1;
            pkt_rx_data = w.data;
            pkt_rx_sop  = w.sop;
            pkt_rx_eop  = w.eop;
            pkt_rx_err  = w.err;
            pkt_rx_mod  = w.mod;
            words_sent++;
         end else begin
            pkt_rx_val  = 1'b0;
            pkt_rx_data = 64'd0;
            pkt_rx_sop  = 1'b0;
            pkt_rx_eop  = 1'b0;
            pkt_rx_err  = 1'b0;
            pkt_rx_mod  = 3'd0;
         end
         pkt_rx_avail = (mac_q.size() != 0);
      end
   end

   // Output monitor: scoreboard compare on every transfer, hold check while
   // stalled, pkt_done pulse counting.
   initial begin : out_monitor
      word_t       e;
      logic [63:0] prev_data  = 64'd0;
      logic        prev_stall = 1'b0;
      forever begin
         @(negedge clk_156m25);
         if (prev_stall && reset_156m25_n) begin
            check("hold_data", out_data, prev_data);
         end
         if (pkt_done) begin
            done_cnt++;
         end
         if (out_val && out_rdy) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got word %0h, required no output", out_data);
            end else begin
               e = sb_q.pop_front();
               check("out_data", out_data, e.data);
               check("out_flags", 64'({out_sop, out_eop, out_err, out_mod}),
                     64'({e.sop, e.eop, e.err, e.mod}));
            end
         end
         prev_stall = reset_156m25_n && out_val && !out_rdy;
         prev_data  = out_data;
      end
   end

   // Read-enable gap monitor: counts ren-low cycles after each MAC eop word
   // while more data is waiting.
   initial begin : gap_monitor
      int   run    = 0;
      logic active = 1'b0;
      logic pend   = 1'b0;
      forever begin
         @(negedge clk_156m25);
         if (pend) begin
            ren_after_eop = pkt_rx_ren;
            pend          = 1'b0;
         end
         if (active && !pkt_rx_avail) begin
            active = 1'b0;
         end else if (active) begin
            if (!pkt_rx_ren) begin
               run++;
            end else begin
               active = 1'b0;
               if (chk_gap) begin
                  gap_checks++;
                  // GAP cycle plus the IDLE cycle that re-arms the read
                  check("gap_cycles", 64'(run), 64'd2);
               end
            end
         end
         if (pkt_rx_val && pkt_rx_eop) begin
            active = 1'b1;
            pend   = 1'b1;
            run    = 0;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin : main
      int base;
      int n;
      word_t stray;

      // Reset state
      repeat (3) @(posedge clk_156m25);
      @(negedge clk_156m25);
      check_all_zero("reset");
      reset_156m25_n = 1'b1;

      // Single 3-word packet, mod=5: 8+8+5 bytes
      send_pkt(1, 3, 3'd5, 1'b0, 1'b0, 1'b1);
      wait_drain("t1", 200);
      check("t1_len",     64'(pkt_len), 64'd21);
      check("t1_pkt_cnt", 64'(stat_pkt_cnt), 64'd1);
      check("t1_done",    64'(done_cnt), 64'd1);
      check("t1_gap_ren", 64'(ren_after_eop), 64'd0);
      check("t1_err_cnt", 64'(stat_err_cnt), 64'd0);

      // Stray word without sop while no packet is open
      stray.data = 64'hDEAD_BEEF_0000_0001;
      stray.sop  = 1'b0;
      stray.eop  = 1'b0;
      stray.err  = 1'b0;
      stray.mod  = 3'd0;
      mac_q.push_back(stray);
      wait_drain("t2", 100);
      check("t2_frm_cnt", 64'(stat_frm_cnt), 64'd1);
      check("t2_out_val", 64'(out_val), 64'd0);
      check("t2_pkt_cnt", 64'(stat_pkt_cnt), 64'd1);

      // Errored packet, exactly-MAX_LEN packet, oversize packet
      send_pkt(2, 2,    3'd3, 1'b1, 1'b1, 1'b1);
      send_pkt(3, 1200, 3'd0, 1'b0, 1'b0, 1'b1);
      send_pkt(4, 1201, 3'd0, 1'b0, 1'b1, 1'b1);
      wait_drain("t3", 6000);
      check("t3_err_cnt", 64'(stat_err_cnt), 64'd2);
      check("t3_pkt_cnt", 64'(stat_pkt_cnt), 64'd4);
      check("t3_len",     64'(pkt_len), 64'd9608);
      check("t3_done",    64'(done_cnt), 64'd4);
      check("t3_frm_cnt", 64'(stat_frm_cnt), 64'd1);

      // Back-pressure: 10-word packet with out_rdy held low
      @(posedge clk_156m25);
      #1;
      out_rdy = 1'b0;
      base    = words_sent;
      send_pkt(5, 10, 3'd0, 1'b0, 1'b0, 1'b1);
      repeat (20) @(posedge clk_156m25);
      @(negedge clk_156m25);
      check("t4_ren_throttled", 64'(pkt_rx_ren), 64'd0);
      check("t4_words_read",    64'(words_sent - base), 64'(FIFO_DEPTH));
      check("t4_out_val",       64'(out_val), 64'd1);
      @(posedge clk_156m25);
      #1;
      out_rdy = 1'b1;
      wait_drain("t4", 300);
      check("t4_len",     64'(pkt_len), 64'd80);
      check("t4_pkt_cnt", 64'(stat_pkt_cnt), 64'd5);
      check("t4_done",    64'(done_cnt), 64'd5);

      // Back-to-back packets with data continuously available
      chk_gap = 1'b1;
      send_pkt(6, 3, 3'd0, 1'b0, 1'b0, 1'b1);
      send_pkt(7, 3, 3'd0, 1'b0, 1'b0, 1'b1);
      send_pkt(8, 3, 3'd0, 1'b0, 1'b0, 1'b1);
      wait_drain("t5", 300);
      chk_gap = 1'b0;
      check("t5_gap_checks", 64'(gap_checks), 64'd2);
      check("t5_pkt_cnt",    64'(stat_pkt_cnt), 64'd8);
      check("t5_done",       64'(done_cnt), 64'd8);
      check("t5_len",        64'(pkt_len), 64'd24);

      // Reset in the middle of a 5-word packet
      @(posedge clk_156m25);
      #1;
      out_rdy = 1'b0;
      base    = words_sent;
      send_pkt(9, 5, 3'd0, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (words_sent < base + 2 && n < 50) begin
         @(posedge clk_156m25);
         #2;
         n++;
      end
      check("t6_two_words_read", 64'(words_sent >= base + 2), 64'd1);
      @(posedge clk_156m25);
      #2;
      reset_156m25_n = 1'b0;
      #1;
      check_all_zero("t6_rst");
      mac_q.delete();
      repeat (3) @(posedge clk_156m25);
      @(negedge clk_156m25);
      reset_156m25_n = 1'b1;
      out_rdy        = 1'b1;

      // Clean single-word packet after reset, mod=4
      send_pkt(10, 1, 3'd4, 1'b0, 1'b0, 1'b1);
      wait_drain("t7", 100);
      check("t7_len",     64'(pkt_len), 64'd4);
      check("t7_pkt_cnt", 64'(stat_pkt_cnt), 64'd1);
      check("t7_err_cnt", 64'(stat_err_cnt), 64'd0);
      check("t7_frm_cnt", 64'(stat_frm_cnt), 64'd0);
      check("t7_done",    64'(done_cnt), 64'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
